// File: rtl/l1_pkg.sv
// Shared L1 definitions: replacement FSM states, default geometry and a
// lowest-set-bit helper used by the victim selector.
package l1_pkg;

  localparam int unsigned L1_WAY_NUM   = 4;
  localparam int unsigned L1_IDX_WIDTH = 6;
  // Widest supported associativity; first1_lsb operates at this width.
  localparam int unsigned L1_MAX_WAYS  = 16;

  typedef enum logic {
    INIT,
    IDLE
  } repl_state_t;

  // One-hot lowest set bit of vec, or 0 when vec is 0.
  function automatic logic [L1_MAX_WAYS-1:0] first1_lsb(input logic [L1_MAX_WAYS-1:0] vec);
    return vec & (~vec + L1_MAX_WAYS'(1));
  endfunction

endpackage

// File: rtl/l1_repl_ctrl_if.sv
// Lookup/allocation bus between a cache pipeline (master) and the
// replacement controller (slave). lock_vect exists only with L1_REPL_LOCK_EN.
interface l1_repl_ctrl_if #(
  parameter int unsigned WAY_NUM   = l1_pkg::L1_WAY_NUM,
  parameter int unsigned IDX_WIDTH = l1_pkg::L1_IDX_WIDTH
);

  logic                 req;
  logic [IDX_WIDTH-1:0] idx;
  logic [WAY_NUM-1:0]   tag_cmp_vect;
  logic [WAY_NUM-1:0]   ld_val_vect;
  logic                 flush_req;
`ifdef L1_REPL_LOCK_EN
  logic [WAY_NUM-1:0]   lock_vect;
`endif
  logic                 ready;
  logic                 hit;
  logic                 evict_val;
  logic                 alloc_fail;
  logic [WAY_NUM-1:0]   way_vect;

  modport master (
`ifdef L1_REPL_LOCK_EN
    output lock_vect,
`endif
    output req, idx, tag_cmp_vect, ld_val_vect, flush_req,
    input  ready, hit, evict_val, alloc_fail, way_vect
  );

  modport slave (
`ifdef L1_REPL_LOCK_EN
    input  lock_vect,
`endif
    input  req, idx, tag_cmp_vect, ld_val_vect, flush_req,
    output ready, hit, evict_val, alloc_fail, way_vect
  );

endinterface

// File: rtl/l1_repl_pick.sv
// Combinational victim selector: invalid ways first, then the lowest
// not-recently-used way, then the lowest allocatable way.
module l1_repl_pick
  import l1_pkg::*;
#(
  parameter int unsigned WAY_NUM = L1_WAY_NUM
) (
  input  logic [WAY_NUM-1:0] ld_val_vect,
  input  logic [WAY_NUM-1:0] used,
  input  logic [WAY_NUM-1:0] alloc_ok,
  output logic [WAY_NUM-1:0] way_vect,
  output logic               evict_val,
  output logic               alloc_fail
);

  logic [WAY_NUM-1:0] free_cand;
  logic [WAY_NUM-1:0] lru_cand;

  // Priority-ordered way selection.
  always_comb begin
    free_cand  = ~ld_val_vect & alloc_ok;
    lru_cand   = ~used & alloc_ok;
    way_vect   = '0;
    evict_val  = 1'b0;
    alloc_fail = 1'b0;
    if (|free_cand) begin
      way_vect = WAY_NUM'(first1_lsb(L1_MAX_WAYS'(free_cand)));
    end else if (|lru_cand) begin
      way_vect  = WAY_NUM'(first1_lsb(L1_MAX_WAYS'(lru_cand)));
      evict_val = 1'b1;
    end else if (|alloc_ok) begin
      way_vect  = WAY_NUM'(first1_lsb(L1_MAX_WAYS'(alloc_ok)));
      evict_val = 1'b1;
    end else begin
      alloc_fail = 1'b1;
    end
  end

endmodule

// File: rtl/l1_repl_ctrl.sv
// L1 replacement controller: per-set MRU bits, same-cycle hit/miss and way
// choice, and an INIT sweep (after reset or flush) that clears the state
// array so the array itself needs no reset.
// Optional feature macro: L1_REPL_LOCK_EN (adds lock_vect, enables alloc_fail).
module l1_repl_ctrl
  import l1_pkg::*;
#(
  parameter int unsigned WAY_NUM   = L1_WAY_NUM,
  parameter int unsigned IDX_WIDTH = L1_IDX_WIDTH
) (
  input logic            clk,
  input logic            rst,
  l1_repl_ctrl_if.slave  bus
);

  localparam int unsigned SET_NUM = 2 ** IDX_WIDTH;

  repl_state_t          state_q, state_d;
  logic [IDX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                 ready_q, ready_d;

  logic [WAY_NUM-1:0]   used_q [SET_NUM];

  logic                 ready;
  logic                 accept;
  logic [WAY_NUM-1:0]   hit_vect;
  logic                 any_hit;
  logic [WAY_NUM-1:0]   used_rd;
  logic [WAY_NUM-1:0]   alloc_ok;
  logic [WAY_NUM-1:0]   pick_way;
  logic                 pick_evict;
  logic                 pick_fail;
  logic [WAY_NUM-1:0]   way_vect;
  logic [WAY_NUM-1:0]   upd;
  logic [WAY_NUM-1:0]   used_wr_data;
  logic                 used_we;

  // FSM next state: sweep one set per cycle, flush restarts the sweep.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      INIT: begin
        sweep_cnt_d = sweep_cnt_q + IDX_WIDTH'(1);
        if (&sweep_cnt_q) state_d = IDLE;
      end
      IDLE: begin
        if (bus.flush_req) begin
          state_d     = INIT;
          sweep_cnt_d = '0;
        end
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // FSM state, sweep counter and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_cnt_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      ready_q     <= ready_d;
    end
  end

`ifdef L1_REPL_LOCK_EN
  assign alloc_ok = ~bus.lock_vect;
`else
  assign alloc_ok = '1;
`endif

  l1_repl_pick #(
    .WAY_NUM (WAY_NUM)
  ) u_pick (
    .ld_val_vect (bus.ld_val_vect),
    .used        (used_rd),
    .alloc_ok    (alloc_ok),
    .way_vect    (pick_way),
    .evict_val   (pick_evict),
    .alloc_fail  (pick_fail)
  );

  // Lookup result and state-update data for the accepted request.
  always_comb begin
    ready    = ready_q & ~rst;
    accept   = bus.req & ready;
    hit_vect = bus.tag_cmp_vect & bus.ld_val_vect;
    any_hit  = |hit_vect;
    used_rd  = used_q[bus.idx];
    way_vect = '0;
    if (accept) way_vect = any_hit ? hit_vect : pick_way;
    // A full MRU vector (locked ways counted as used) restarts from this way.
    upd          = used_rd | way_vect;
    used_wr_data = (&(upd | ~alloc_ok)) ? way_vect : upd;
    used_we      = accept & (any_hit | ~pick_fail);
  end

  assign bus.ready     = ready;
  assign bus.hit       = accept & any_hit;
  assign bus.evict_val = accept & ~any_hit & pick_evict;
  assign bus.way_vect  = way_vect;
`ifdef L1_REPL_LOCK_EN
  assign bus.alloc_fail = accept & ~any_hit & pick_fail;
`else
  assign bus.alloc_fail = 1'b0;
`endif

  // State array: cleared by the sweep, otherwise written by accepted requests.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      used_q[sweep_cnt_q] <= '0;
    end else if (used_we) begin
      used_q[bus.idx] <= used_wr_data;
    end
  end

endmodule

// File: tb/tb_l1_repl_ctrl.sv
// Self-checking bench for l1_repl_ctrl (WAY_NUM=4, IDX_WIDTH=2) with a
// behavioural replacement model. Lock scenarios build with L1_REPL_LOCK_EN.
module tb_l1_repl_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  logic rst;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [W-1:0] model_used [NS];

  l1_repl_ctrl_if #(.WAY_NUM(W), .IDX_WIDTH(IW)) bus ();

  l1_repl_ctrl #(.WAY_NUM(W), .IDX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: evaluate one lookup from the replacement rules.
  function automatic void model_eval(input logic rq, input int ix,
                                     input logic [W-1:0] tg, vl, lk,
                                     output logic [6:0] exp_o,
                                     output logic we, output logic [W-1:0] nu);
    logic [W-1:0] ok, way;
    logic h, ev, fl, sat;
    int sel;
    ok = ~lk; way = '0; h = 0; ev = 0; fl = 0; we = 0;
    nu = model_used[ix];
    exp_o = '0;
    if (!rq) return;
    if ((tg & vl) != 0) begin
      h = 1; way = tg & vl;
    end else begin
      sel = -1;
      for (int i = 0; i < W; i++) if (sel < 0 && !vl[i] && ok[i]) sel = i;
      if (sel < 0) begin
        for (int i = 0; i < W; i++) if (sel < 0 && !model_used[ix][i] && ok[i]) sel = i;
        if (sel >= 0) ev = 1;
      end
      if (sel < 0) begin
        for (int i = 0; i < W; i++) if (sel < 0 && ok[i]) sel = i;
        if (sel >= 0) ev = 1;
      end
      if (sel < 0) fl = 1;
      else way = W'(1 << sel);
    end
    if (!fl) begin
      we = 1;
      nu = model_used[ix] | way;
      sat = 1;
      for (int i = 0; i < W; i++) if (!nu[i] && ok[i]) sat = 0;
      if (sat) nu = way;
    end
    exp_o = {h, ev, fl, way};
  endfunction

  // One lookup cycle while the controller is idle; returns observed outputs.
  task automatic access(input logic rq, input logic [IW-1:0] ix,
                        input logic [W-1:0] tg, vl, lk, input logic fl,
                        input string nm, output logic [6:0] obs);
    logic [6:0] exp_v;
    logic we;
    logic [W-1:0] nu;
    @(negedge clk);
    bus.req = rq; bus.idx = ix; bus.tag_cmp_vect = tg; bus.ld_val_vect = vl;
    bus.flush_req = fl;
`ifdef L1_REPL_LOCK_EN
    bus.lock_vect = lk;
`endif
    #1;
    assert ($onehot0(tg & vl)) else $error("protocol: multiple tag hits in %s", nm);
    model_eval(rq, int'(ix), tg, vl, lk, exp_v, we, nu);
    obs = {bus.hit, bus.evict_val, bus.alloc_fail, bus.way_vect};
    n_checks++;
    if (obs !== exp_v)
      $display("FAIL %s: {hit,evict,fail,way} got %b expected %b (idx %0d)", nm, obs, exp_v, ix);
    else n_pass++;
    @(posedge clk);
    #1;
    if (we) model_used[ix] = nu;
    if (fl && rq) for (int i = 0; i < NS; i++) model_used[i] = '0;
    else if (fl) for (int i = 0; i < NS; i++) model_used[i] = '0;
    bus.req = 1'b0; bus.flush_req = 1'b0;
  endtask

  task automatic check_array(input string nm);
    for (int i = 0; i < NS; i++) begin
      n_checks++;
      if (dut.used_q[i] !== model_used[i])
        $display("FAIL %s: used[%0d] got %b expected %b", nm, i, dut.used_q[i], model_used[i]);
      else n_pass++;
    end
  endtask

  // Counts edges after a sweep start; ready must rise exactly at edge NS.
  task automatic check_sweep(input string nm);
    logic [6:0] outs;
    for (int k = 1; k <= NS; k++) begin
      @(posedge clk);
      #1;
      outs = {bus.hit, bus.evict_val, bus.alloc_fail, bus.way_vect};
      n_checks++;
      if (bus.ready !== (k == NS))
        $display("FAIL %s: ready got %b expected %b at edge %0d", nm, bus.ready, (k == NS), k);
      else n_pass++;
      if (k < NS) begin
        n_checks++;
        if (outs !== 7'd0) $display("FAIL %s_outs: got %b expected 0 at edge %0d", nm, outs, k);
        else n_pass++;
      end
    end
    bus.req = 1'b0; bus.flush_req = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] outs;
    rst = 1'b1;
    bus.req = 1'b1; bus.idx = '0; bus.tag_cmp_vect = 4'b0001; bus.ld_val_vect = 4'b1111;
    bus.flush_req = 1'b0;
`ifdef L1_REPL_LOCK_EN
    bus.lock_vect = '0;
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      outs = {bus.ready, bus.hit, bus.evict_val, bus.alloc_fail, bus.way_vect[2:0]};
      n_checks++;
      if ({bus.ready, bus.hit, bus.evict_val, bus.alloc_fail, bus.way_vect} !== 8'd0)
        $display("FAIL reset_hold: outputs got %b expected 0", outs);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    check_sweep("reset_release");
    for (int i = 0; i < NS; i++) model_used[i] = '0;
    check_array("reset_array");
  endtask

  task automatic test_fill;
    logic [6:0] obs;
    access(1, 2'd1, 4'b0000, 4'b0011, 4'b0000, 0, "fill_miss", obs);
    n_checks++;
    if (obs !== 7'b000_0100) $display("FAIL fill_way: got %b expected 0000100", obs);
    else n_pass++;
    n_checks++;
    if (dut.used_q[1] !== 4'b0100) $display("FAIL fill_used: got %b expected 0100", dut.used_q[1]);
    else n_pass++;
  endtask

  task automatic test_saturation;
    logic [6:0] obs;
    for (int i = 0; i < W; i++) begin
      access(1, 2'd2, 4'b0000, 4'b1111, 4'b0000, 0, "sat_miss", obs);
      n_checks++;
      if (obs[3:0] !== 4'(1 << i) || obs[5] !== 1'b1)
        $display("FAIL sat_seq: step %0d got %b expected way %b evict 1", i, obs, 4'(1 << i));
      else n_pass++;
    end
    n_checks++;
    if (dut.used_q[2] !== 4'b1000) $display("FAIL sat_used: got %b expected 1000", dut.used_q[2]);
    else n_pass++;
    access(1, 2'd2, 4'b0000, 4'b1111, 4'b0000, 0, "sat_wrap", obs);
    n_checks++;
    if (obs !== 7'b010_0001) $display("FAIL sat_wrap_way: got %b expected 0100001", obs);
    else n_pass++;
  endtask

  task automatic test_hit;
    logic [6:0] obs;
    access(1, 2'd3, 4'b0010, 4'b1111, 4'b0000, 0, "hit", obs);
    n_checks++;
    if (obs !== 7'b100_0010) $display("FAIL hit_out: got %b expected 1000010", obs);
    else n_pass++;
    n_checks++;
    if (dut.used_q[3][1] !== 1'b1) $display("FAIL hit_used: got %b expected bit1 set", dut.used_q[3]);
    else n_pass++;
  endtask

`ifdef L1_REPL_LOCK_EN
  task automatic test_lock;
    logic [6:0] obs;
    access(1, 2'd0, 4'b0000, 4'b1111, 4'b0011, 0, "lock_partial", obs);
    n_checks++;
    if (obs[3:0] !== 4'b0100 || obs[4] !== 1'b0)
      $display("FAIL lock_partial_way: got %b expected way 0100", obs);
    else n_pass++;
    access(1, 2'd0, 4'b0000, 4'b1111, 4'b1111, 0, "lock_all", obs);
    n_checks++;
    if (obs !== 7'b001_0000) $display("FAIL lock_all_out: got %b expected 0010000", obs);
    else n_pass++;
    n_checks++;
    if (dut.used_q[0] !== 4'b0100) $display("FAIL lock_all_used: got %b expected 0100", dut.used_q[0]);
    else n_pass++;
  endtask
`endif

  // Random back-to-back traffic, including idle cycles and hits.
  task automatic test_random;
    logic [6:0] obs;
    logic rq;
    logic [IW-1:0] ix;
    logic [W-1:0] tg, vl, lk;
    for (int n = 0; n < 300; n++) begin
      rq = ($urandom_range(0, 4) != 0);
      ix = IW'($urandom);
      vl = W'($urandom);
      if ($urandom_range(0, 1) == 1) tg = W'(1 << $urandom_range(0, W - 1)) | (W'($urandom) & ~vl);
      else tg = W'($urandom) & ~vl;
`ifdef L1_REPL_LOCK_EN
      lk = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`else
      lk = '0;
`endif
      access(rq, ix, tg, vl, lk, 0, "random", obs);
    end
    check_array("random_array");
  endtask

  task automatic test_flush;
    logic [6:0] obs;
    access(1, 2'd1, 4'b0000, 4'b1111, 4'b0000, 1, "flush_req_served", obs);
    n_checks++;
    if (bus.ready !== 1'b0) $display("FAIL flush_ready_drop: got %b expected 0", bus.ready);
    else n_pass++;
    bus.req = 1'b1; bus.flush_req = 1'b1;
    bus.tag_cmp_vect = 4'b0001; bus.ld_val_vect = 4'b1111;
    check_sweep("flush_sweep");
    check_array("flush_array");
  endtask

  task automatic test_reset_midsweep;
    logic [6:0] obs;
    for (int i = 0; i < NS; i++)
      access(1, IW'(i), 4'b0000, 4'b1111, 4'b0000, 0, "pre_fill", obs);
    access(0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1, "midsweep_flush", obs);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) $display("FAIL midsweep_rst_ready: got %b expected 0", bus.ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    check_sweep("midsweep_restart");
    check_array("midsweep_array");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_saturation();
    test_hit();
`ifdef L1_REPL_LOCK_EN
    test_lock();
`endif
    test_random();
    test_flush();
    test_reset_midsweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l1_repl_ctrl.md
# l1_repl_ctrl

Parametrised replacement controller for the L1 instruction and data caches. It supersedes the fixed-geometry MRU-bit replacement logic. It resolves hit/miss and picks a way per lookup in the same cycle, prefers invalid ways before evicting, and keeps per-set MRU state. A sequential init/flush sweep clears the state array, so the array needs no reset and can map to flops or a small RAM.

## Interface
- `WAY_NUM`, 4: associativity; power of two, 2..16.
- `IDX_WIDTH`, 6: set index width; `SET_NUM = 2**IDX_WIDTH`.
- `clk` input 1: clock.
- `rst` input 1: reset; synchronous and active-high.
- `req` input 1: lookup/access request; accepted when `req & ready`.
- `idx` input `IDX_WIDTH`: set index.
- `tag_cmp_vect` input `WAY_NUM`: per-way tag match.
- `ld_val_vect` input `WAY_NUM`: per-way line valid.
- `flush_req` input 1: pulse; clears all replacement state.
- `lock_vect` input `WAY_NUM`: ways excluded from allocation. Present only with `L1_REPL_LOCK_EN`.
- `ready` output 1: controller idle and accepting `req`.
- `hit` output 1: `req & ready & |(tag_cmp_vect & ld_val_vect)`.
- `evict_val` output 1: miss whose chosen way holds a valid line.
- `alloc_fail` output 1: miss with no allocatable way.
- `way_vect` output `WAY_NUM`: one-hot hit way or allocation way; 0 when `alloc_fail`.

## Operation
- State: `used_r[SET_NUM]`, `WAY_NUM` bits each. FSM has two states, `INIT` and `IDLE`, plus `sweep_cnt` of width `IDX_WIDTH`.
- `INIT`: writes `used_r[sweep_cnt] <= 0`, one set per cycle. `sweep_cnt` counts 0..SET_NUM-1; at SET_NUM-1 the FSM goes to `IDLE`. `ready` is 0 throughout.
- `IDLE`: `ready` is 1. If `flush_req` is set, the next state is `INIT` with `sweep_cnt` = 0.
- `req` and `flush_req` in the same `IDLE` cycle: the request is served and its update written, then the sweep starts. `flush_req` while in `INIT` is ignored.
- Hit: `way_vect` = hit vector. Multiple tag hits are a protocol error; the bench asserts against them.
- Miss: the allocation mask is `alloc_ok = ~lock_vect`, or all-ones when locking is compiled out. Way selection, in priority order:
  1. The lowest-index way in `~ld_val_vect & alloc_ok`. `evict_val` = 0.
  2. Otherwise, the lowest-index way in `~used_r[idx] & alloc_ok`. `evict_val` = 1.
  3. Otherwise, the lowest-index way in `alloc_ok`. `evict_val` = 1.
  4. If `alloc_ok` = 0: `alloc_fail` = 1, `way_vect` = 0, `evict_val` = 0, no state update.
- Update, on an accepted request without `alloc_fail`: `upd = used_r[idx] | way_vect`. If `&(upd | ~alloc_ok)` is true, write `way_vect`; otherwise write `upd`. Locked ways therefore count as used for saturation.
- Outputs are all 0 whenever `!(req & ready)`.

## Timing
- `hit`, `evict_val`, `alloc_fail` and `way_vect` are combinational from the inputs and `used_r` in the request cycle.
- The state write lands at the next rising edge. A back-to-back request to the same `idx` sees the updated state; no bypass is needed.
- Reset: `rst` high forces `INIT` and `sweep_cnt` = 0. `ready` is 0 while `rst` is high and for SET_NUM cycles after it falls, and rises at edge SET_NUM after deassertion.
- Reset mid-sweep restarts the sweep from set 0. A flush also takes exactly SET_NUM cycles with `ready` = 0.
- All other outputs are 0 during reset and `INIT`.

## Configuration
- `L1_REPL_LOCK_EN` defined: the `lock_vect` port exists, locked ways are never allocated, and `alloc_fail` can assert.
- Not defined: the port is absent, `alloc_ok` is all-ones, and `alloc_fail` is tied to 0.

## Structure
- Shared package `l1_pkg`:
  - FSM enum `repl_state_t` (`INIT`, `IDLE`).
  - Function `first1_lsb(vec)`, returning a one-hot lowest set bit, or 0 for 0.
  - Default constants `L1_WAY_NUM` and `L1_IDX_WIDTH`.
- One sub-module, `l1_repl_pick`: a purely combinational victim selector. Inputs are `ld_val_vect`, `used`, `alloc_ok`; outputs are `way_vect`, `evict_val`, `alloc_fail`.
- The FSM, sweep counter and state array stay in `l1_repl_ctrl`.

## Test plan
Configuration: WAY_NUM=4, IDX_WIDTH=2.
- Reset: release `rst` -> `ready` = 0 for 4 cycles and 1 on cycle 4; every `used_r` entry = 0; outputs 0 throughout.
- Invalid-first fill, set 1: `ld_val_vect` = 0011, miss -> `way_vect` = 0100, `evict_val` = 0; `used_r[1]` = 0100.
- MRU saturation, set 2, all ways valid: misses give ways 0001, 0010, 0100, 1000. The fourth write leaves `used_r[2]` = 1000, and the next miss gives 0001 with `evict_val` = 1.
- Hit update: `tag_cmp_vect` = 0010 with `ld_val_vect` = 1111 -> `hit` = 1, `way_vect` = 0010, `evict_val` = 0; bit 1 is set in `used_r`.
- Flush with simultaneous request: `flush_req` and `req` in the same `IDLE` cycle -> the request is served, then `ready` = 0 for 4 cycles. `rst` asserted mid-sweep at count 2 -> the sweep restarts at 0.
- With `L1_REPL_LOCK_EN`, all ways valid and `used_r` = 0:
  - `lock_vect` = 0011 -> miss selects 0100.
  - `lock_vect` = 1111 -> `alloc_fail` = 1, `way_vect` = 0, `used_r` unchanged.
